// File: rtl/frogger_game_ctrl.sv
// Frame-synchronous Frogger game controller: latches button edges into a pending move,
// steps the player and cars once per FRAME_TICK, then checks collisions and sequences IDLE/PLAY/HIT/WIN.
module frogger_game_ctrl #(
   parameter int H_DISPLAY     = 640,
   parameter int V_DISPLAY     = 480,
   parameter int PLAYER_WIDTH  = 32,
   parameter int PLAYER_HEIGHT = 32,
   parameter int CAR_WIDTH     = 64,
   parameter int CAR_HEIGHT    = 32,
   parameter int STEP          = 32,
   parameter int PAUSE_FRAMES  = 60
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        FRAME_TICK,
   input  logic        BTN_UP,
   input  logic        BTN_DOWN,
   input  logic        BTN_LEFT,
   input  logic        BTN_RIGHT,
   output logic [9:0]  player_x,
   output logic [9:0]  player_y,
   output logic [39:0] car_x,
   output logic [39:0] car_y,
   output logic [1:0]  game_state,
   output logic [1:0]  lives,
   output logic [3:0]  level
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PLAY = 2'd1,
      S_HIT  = 2'd2,
      S_WIN  = 2'd3
   } state_t;

   typedef enum logic [2:0] {
      MV_NONE  = 3'd0,
      MV_UP    = 3'd1,
      MV_DOWN  = 3'd2,
      MV_LEFT  = 3'd3,
      MV_RIGHT = 3'd4
   } move_t;

   localparam int            PCW        = $clog2(PAUSE_FRAMES + 1);
   localparam logic [PCW-1:0] PAUSE_LAST = PCW'(PAUSE_FRAMES - 1);
   localparam logic [10:0]   H_W        = 11'(H_DISPLAY);
   localparam logic [10:0]   STEP_W     = 11'(STEP);
   localparam logic [10:0]   X_MAX      = 11'(H_DISPLAY - PLAYER_WIDTH);
   localparam logic [10:0]   Y_MAX      = 11'(V_DISPLAY - PLAYER_HEIGHT);
   localparam logic [9:0]    X_START    = 10'((H_DISPLAY - PLAYER_WIDTH) / 2);
   localparam logic [9:0]    Y_START    = 10'(V_DISPLAY - PLAYER_HEIGHT);

   // Cars start evenly spread across the screen, one per lane.
   function automatic logic [9:0] car_home_x(input int idx);
      return 10'(idx * (H_DISPLAY / 4));
   endfunction

   function automatic logic [9:0] car_lane_y(input int idx);
      return 10'((idx + 1) * 3 * CAR_HEIGHT);
   endfunction

   function automatic logic [9:0] car_right(input logic [9:0] x, input logic [3:0] lvl);
      logic [10:0] s;
      s = {1'b0, x} + {7'd0, lvl};
      if (s >= H_W) begin
         return 10'(s - H_W);
      end else begin
         return 10'(s);
      end
   endfunction

   function automatic logic [9:0] car_left(input logic [9:0] x, input logic [3:0] lvl);
      logic [10:0] s;
      s = {1'b0, x};
      if (s < {7'd0, lvl}) begin
         return 10'(s + H_W - {7'd0, lvl});
      end else begin
         return 10'(s - {7'd0, lvl});
      end
   endfunction

   state_t         state_q, state_d;
   move_t          pend_q, pend_d, edge_mv_s;
   logic [1:0]     lives_q, lives_d;
   logic [3:0]     level_q, level_d;
   logic [9:0]     px_q, px_d, py_q, py_d;
   logic [9:0]     cx_q [4];
   logic [9:0]     cx_d [4];
   logic [3:0]     btn_q, btn_d, btn_s, rise_s;
   logic           win_q, win_d, chk_q, chk_d, hit_s;
   logic [PCW-1:0] pause_q, pause_d;

   assign btn_s  = {BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT};
   assign rise_s = btn_s & ~btn_q;

   // Highest-priority rising edge this cycle, UP first.
   always_comb begin
      edge_mv_s = MV_NONE;
      if (rise_s[3]) begin
         edge_mv_s = MV_UP;
      end else if (rise_s[2]) begin
         edge_mv_s = MV_DOWN;
      end else if (rise_s[1]) begin
         edge_mv_s = MV_LEFT;
      end else if (rise_s[0]) begin
         edge_mv_s = MV_RIGHT;
      end else begin
         edge_mv_s = MV_NONE;
      end
   end

   // Box overlap between player and each car using unwrapped 11-bit sums.
   always_comb begin
      hit_s = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (({1'b0, px_q} < {1'b0, cx_q[i]} + 11'(CAR_WIDTH)) &&
             ({1'b0, cx_q[i]} < {1'b0, px_q} + 11'(PLAYER_WIDTH)) &&
             ({1'b0, py_q} < {1'b0, car_lane_y(i)} + 11'(CAR_HEIGHT)) &&
             ({1'b0, car_lane_y(i)} < {1'b0, py_q} + 11'(PLAYER_HEIGHT))) begin
            hit_s = 1'b1;
         end else begin
            hit_s = hit_s;
         end
      end
   end

   // Next-state logic for the game sequence, pending move and positions.
   always_comb begin
      state_d = state_q;
      lives_d = lives_q;
      level_d = level_q;
      px_d    = px_q;
      py_d    = py_q;
      cx_d    = cx_q;
      win_d   = win_q;
      chk_d   = chk_q;
      pause_d = pause_q;
      btn_d   = btn_s;

      // An edge on the tick cycle belongs to the next frame.
      if (FRAME_TICK) begin
         pend_d = edge_mv_s;
      end else if (pend_q == MV_NONE) begin
         pend_d = edge_mv_s;
      end else begin
         pend_d = pend_q;
      end

      case (state_q)
         S_IDLE: begin
            if (FRAME_TICK && (pend_q != MV_NONE)) begin
               state_d = S_PLAY;
               lives_d = 2'd3;
               level_d = 4'd1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_PLAY: begin
            if (FRAME_TICK) begin
               chk_d = 1'b1;
               case (pend_q)
                  MV_UP: begin
                     if ({1'b0, py_q} < STEP_W) begin
                        win_d = 1'b1;
                     end else begin
                        py_d = 10'({1'b0, py_q} - STEP_W);
                     end
                  end
                  MV_DOWN: begin
                     if ({1'b0, py_q} + STEP_W > Y_MAX) begin
                        py_d = 10'(Y_MAX);
                     end else begin
                        py_d = 10'({1'b0, py_q} + STEP_W);
                     end
                  end
                  MV_LEFT: begin
                     if ({1'b0, px_q} < STEP_W) begin
                        px_d = 10'd0;
                     end else begin
                        px_d = 10'({1'b0, px_q} - STEP_W);
                     end
                  end
                  MV_RIGHT: begin
                     if ({1'b0, px_q} + STEP_W > X_MAX) begin
                        px_d = 10'(X_MAX);
                     end else begin
                        px_d = 10'({1'b0, px_q} + STEP_W);
                     end
                  end
                  default: begin
                     px_d = px_q;
                  end
               endcase
               cx_d[0] = car_right(cx_q[0], level_q);
               cx_d[1] = car_left(cx_q[1], level_q);
               cx_d[2] = car_right(cx_q[2], level_q);
               cx_d[3] = car_left(cx_q[3], level_q);
            end else if (chk_q) begin
               chk_d = 1'b0;
               win_d = 1'b0;
               if (hit_s) begin
                  state_d = S_HIT;
               end else if (win_q) begin
                  state_d = S_WIN;
               end else begin
                  state_d = S_PLAY;
               end
            end else begin
               state_d = S_PLAY;
            end
         end
         S_HIT, S_WIN: begin
            if (FRAME_TICK) begin
               if (pause_q == PAUSE_LAST) begin
                  pause_d = {PCW{1'b0}};
                  px_d    = X_START;
                  py_d    = Y_START;
                  if (state_q == S_WIN) begin
                     level_d = (level_q == 4'd15) ? level_q : level_q + 4'd1;
                     for (int i = 0; i < 4; i++) begin
                        cx_d[i] = car_home_x(i);
                     end
                     state_d = S_PLAY;
                  end else if (lives_q == 2'd1) begin
                     // Game over: everything back to power-on values.
                     state_d = S_IDLE;
                     lives_d = 2'd3;
                     level_d = 4'd1;
                     pend_d  = MV_NONE;
                     win_d   = 1'b0;
                     chk_d   = 1'b0;
                     for (int i = 0; i < 4; i++) begin
                        cx_d[i] = car_home_x(i);
                     end
                  end else begin
                     lives_d = lives_q - 2'd1;
                     state_d = S_PLAY;
                  end
               end else begin
                  pause_d = pause_q + {{(PCW-1){1'b0}}, 1'b1};
               end
            end else begin
               pause_d = pause_q;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and position registers.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= S_IDLE;
         pend_q  <= MV_NONE;
         lives_q <= 2'd3;
         level_q <= 4'd1;
         px_q    <= X_START;
         py_q    <= Y_START;
         btn_q   <= 4'd0;
         win_q   <= 1'b0;
         chk_q   <= 1'b0;
         pause_q <= {PCW{1'b0}};
         for (int i = 0; i < 4; i++) begin
            cx_q[i] <= car_home_x(i);
         end
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         lives_q <= lives_d;
         level_q <= level_d;
         px_q    <= px_d;
         py_q    <= py_d;
         btn_q   <= btn_d;
         win_q   <= win_d;
         chk_q   <= chk_d;
         pause_q <= pause_d;
         for (int i = 0; i < 4; i++) begin
            cx_q[i] <= cx_d[i];
         end
      end
   end

   assign player_x   = px_q;
   assign player_y   = py_q;
   assign car_x      = {cx_q[3], cx_q[2], cx_q[1], cx_q[0]};
   assign car_y      = {car_lane_y(3), car_lane_y(2), car_lane_y(1), car_lane_y(0)};
   assign game_state = state_q;
   assign lives      = lives_q;
   assign level      = level_q;

endmodule

// File: tb/tb_frogger_game_ctrl.sv
// Random-stimulus bench for frogger_game_ctrl, checked every cycle against a frame-level game model.
module tb_frogger_game_ctrl;

   logic        CLK = 1'b0;
   logic        RST_N, FRAME_TICK, BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT;
   logic [9:0]  player_x, player_y;
   logic [39:0] car_x, car_y;
   logic [1:0]  game_state, lives;
   logic [3:0]  level;

   frogger_game_ctrl dut (
      .CLK(CLK), .RST_N(RST_N), .FRAME_TICK(FRAME_TICK),
      .BTN_UP(BTN_UP), .BTN_DOWN(BTN_DOWN), .BTN_LEFT(BTN_LEFT), .BTN_RIGHT(BTN_RIGHT),
      .player_x(player_x), .player_y(player_y), .car_x(car_x), .car_y(car_y),
      .game_state(game_state), .lives(lives), .level(level)
   );

   always #5 CLK = ~CLK;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Game model: 0 idle, 1 play, 2 hit, 3 win; moves 0 none, 1 up, 2 down, 3 left, 4 right.
   int m_state, m_lives, m_level, m_px, m_py, m_pend, m_pause;
   int m_cx [4];
   bit m_win, m_chk;
   logic [3:0] m_prev;
   int home_x [4] = '{0, 160, 320, 480};
   int lane_y [4] = '{96, 192, 288, 384};

   task automatic model_restore();
      m_state = 0; m_lives = 3; m_level = 1; m_px = 304; m_py = 448;
      m_pend = 0; m_pause = 0; m_win = 0; m_chk = 0;
      for (int i = 0; i < 4; i++) m_cx[i] = home_x[i];
   endtask

   task automatic model_reset();
      model_restore();
      m_prev = 4'd0;
   endtask

   function automatic bit model_overlap();
      for (int i = 0; i < 4; i++) begin
         if (m_px < m_cx[i] + 64 && m_cx[i] < m_px + 32 &&
             m_py < lane_y[i] + 32 && lane_y[i] < m_py + 32) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic model_step(input bit tick, input logic [3:0] b);
      logic [3:0] e;
      int first, req;
      e = b & ~m_prev;
      m_prev = b;
      first = e[3] ? 1 : e[2] ? 2 : e[1] ? 3 : e[0] ? 4 : 0;
      req = m_pend;
      m_pend = (tick || m_pend == 0) ? first : m_pend;
      case (m_state)
         0: if (tick && req != 0) begin
            m_state = 1; m_lives = 3; m_level = 1;
         end
         1: if (tick) begin
            if (req == 1) begin
               if (m_py < 32) m_win = 1; else m_py = m_py - 32;
            end
            if (req == 2) m_py = (m_py + 32 > 448) ? 448 : m_py + 32;
            if (req == 3) m_px = (m_px < 32) ? 0 : m_px - 32;
            if (req == 4) m_px = (m_px + 32 > 608) ? 608 : m_px + 32;
            for (int i = 0; i < 4; i++) begin
               if (i % 2 == 0) m_cx[i] = (m_cx[i] + m_level) % 640;
               else            m_cx[i] = (m_cx[i] - m_level + 640) % 640;
            end
            m_chk = 1;
         end else if (m_chk) begin
            m_chk = 0;
            if (model_overlap()) m_state = 2;
            else if (m_win) m_state = 3;
            m_win = 0;
         end
         default: if (tick) begin
            m_pause++;
            if (m_pause == 60) begin
               m_pause = 0;
               if (m_state == 2 && m_lives == 1) begin
                  model_restore();
               end else begin
                  if (m_state == 2) m_lives--;
                  else begin
                     m_level = (m_level < 15) ? m_level + 1 : 15;
                     for (int i = 0; i < 4; i++) m_cx[i] = home_x[i];
                  end
                  m_px = 304; m_py = 448; m_state = 1;
               end
            end
         end
      endcase
   endtask

   task automatic compare_all();
      check_val("game_state", game_state, m_state);
      check_val("lives", lives, m_lives);
      check_val("level", level, m_level);
      check_val("player_x", player_x, m_px);
      check_val("player_y", player_y, m_py);
      for (int i = 0; i < 4; i++) check_val($sformatf("car%0d_x", i), car_x[i*10 +: 10], m_cx[i]);
      check_val("car_y", car_y, {10'd384, 10'd288, 10'd192, 10'd96});
   endtask

   task automatic check_reset_values(input string tag);
      check_val({tag, "_state"}, game_state, 2'd0);
      check_val({tag, "_lives"}, lives, 2'd3);
      check_val({tag, "_level"}, level, 4'd1);
      check_val({tag, "_px"}, player_x, 10'd304);
      check_val({tag, "_py"}, player_y, 10'd448);
      check_val({tag, "_car_x"}, car_x, {10'd480, 10'd320, 10'd160, 10'd0});
   endtask

   task automatic step(input bit tick, input logic [3:0] b);
      FRAME_TICK = tick;
      {BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT} = b;
      @(posedge CLK);
      if (RST_N) model_step(tick, b);
      else model_reset();
      #1;
      compare_all();
   endtask

   task automatic async_reset_pulse(input string tag);
      #3;
      RST_N = 1'b0;
      #1;
      check_reset_values(tag);
      model_reset();
      step(1'b1, 4'b0000);
      step(1'b0, 4'b0000);
      RST_N = 1'b1;
   endtask

   initial begin
      int gap, r;
      bit tick, did_rst;
      logic [3:0] b;
      RST_N = 1'b0; FRAME_TICK = 1'b0;
      {BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT} = 4'b0000;
      model_reset();
      #12;
      check_reset_values("por");
      @(negedge CLK);
      RST_N = 1'b1;
      gap = 2; b = 4'b0000; did_rst = 1'b0;

      for (int cyc = 0; cyc < 30000; cyc++) begin
         if (gap == 0) begin
            tick = 1'b1;
            gap = $urandom_range(0, 5);
         end else begin
            tick = 1'b0;
            gap--;
         end
         r = $urandom_range(0, 15);
         if (r < 3)      b = 4'b0000;
         else if (r < 4) b = 4'($urandom_range(0, 15));
         else if (r < 6) b = 4'b1000;
         else if (r < 7) b = 4'(4'b0001 << $urandom_range(0, 2));
         else            b = b;
         step(tick, b);
         if (!did_rst && m_state == 2 && m_pause == 30) begin
            did_rst = 1'b1;
            async_reset_pulse("hit_rst");
            b = 4'b0000;
         end
      end
      if (!did_rst) async_reset_pulse("end_rst");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
